// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte/half/word load-store unit with request handshake and configurable read latency
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (fault misaligned half/word accesses instead of aligning down).
module dmem_lsu #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] add,
    input  logic [31:0]       data_in,
    output logic              rsp_valid,
    output logic [31:0]       data_out,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              accept, fault, misalign, issue_now, issue_pend;
    logic [3:0]        be;
    logic [31:0]       wdata, rword, ldata;
    logic [7:0]        bsel;
    logic [15:0]       hsel;
    logic [31:0]       hold_data;
    logic              hold_err;
    logic              unused_addr;

    assign idx         = add[2 +: IDX_W];
    assign lane        = add[1:0];
    assign rword       = mem[idx];
    assign unused_addr = ^add[ADDR_W-1:IDX_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && lane[0]) || ((req_size == 2'b10) && (lane != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign fault = (req_size == 2'b11) || misalign;

    always_comb begin
        be    = 4'b0000;
        wdata = data_in;
        case (req_size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{data_in[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data_in[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        bsel  = rword[{lane, 3'b000} +: 8];
        hsel  = lane[1] ? rword[31:16] : rword[15:0];
        ldata = '0;
        case (req_size)
            2'b00:   ldata = {{24{~req_unsigned & bsel[7]}}, bsel};
            2'b01:   ldata = {{16{~req_unsigned & hsel[15]}}, hsel};
            2'b10:   ldata = rword;
            default: ldata = '0;
        endcase
        if (fault) ldata = '0;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        accept     = 1'b0;
        issue_now  = 1'b0;
        issue_pend = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                accept    = req_valid & ~rst;
                if (accept) begin
                    if (req_wen || RD_LAT == 1) begin
                        issue_now = 1'b1;
                    end else begin
                        state_nxt = RD_WAIT;
                        cnt_nxt   = 2'(RD_LAT - 1);
                    end
                end
            end
            RD_WAIT: begin
                cnt_nxt = cnt - 2'd1;
                if (cnt == 2'd1) begin
                    state_nxt  = IDLE;
                    issue_pend = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            rsp_valid <= 1'b0;
            data_out  <= '0;
            rsp_err   <= 1'b0;
            hold_data <= '0;
            hold_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= 1'b0;
            data_out  <= '0;
            rsp_err   <= 1'b0;
            if (accept && !req_wen) begin
                hold_data <= ldata;
                hold_err  <= fault;
            end
            if (issue_now) begin
                rsp_valid <= 1'b1;
                data_out  <= req_wen ? 32'd0 : ldata;
                rsp_err   <= fault;
            end else if (issue_pend) begin
                rsp_valid <= 1'b1;
                data_out  <= hold_data;
                rsp_err   <= hold_err;
            end
        end
    end

    // Array is deliberately not reset; faulting stores leave it untouched.
    always_ff @(posedge clk) begin
        if (accept && req_wen && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu at RD_LAT 1 and 3
module tb_dmem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid, a_ready, a_wen, a_uns, a_rsp_valid, a_rsp_err;
    logic [1:0]  a_size;
    logic [31:0] a_add, a_din, a_dout;
    logic        b_valid, b_ready, b_wen, b_uns, b_rsp_valid, b_rsp_err;
    logic [1:0]  b_size;
    logic [31:0] b_add, b_din, b_dout;

    int n_chk  = 0;
    int n_pass = 0;

    dmem_lsu #(.DEPTH(256), .ADDR_W(32), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_wen(a_wen),
        .req_size(a_size), .req_unsigned(a_uns), .add(a_add), .data_in(a_din),
        .rsp_valid(a_rsp_valid), .data_out(a_dout), .rsp_err(a_rsp_err)
    );

    dmem_lsu #(.DEPTH(256), .ADDR_W(32), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_wen(b_wen),
        .req_size(b_size), .req_unsigned(b_uns), .add(b_add), .data_in(b_din),
        .rsp_valid(b_rsp_valid), .data_out(b_dout), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic op1(input logic wen, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] q, output logic e, output logic v);
        int n = 0;
        a_wen = wen; a_size = sz; a_uns = uns; a_add = a; a_din = d; a_valid = 1'b1;
        while (!a_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_ready_before_accept", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        v = a_rsp_valid; q = a_dout; e = a_rsp_err;
    endtask

    task automatic st1(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err);
        logic [31:0] q; logic e, v;
        op1(1'b1, sz, 1'b0, a, d, q, e, v);
        check({tag, "_valid"}, v, 1);
        check({tag, "_data"}, q, 32'd0);
        check({tag, "_err"}, e, exp_err);
    endtask

    task automatic ld1(input string tag, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] exp_q, input logic exp_err);
        logic [31:0] q; logic e, v;
        op1(1'b0, sz, uns, a, 32'h0, q, e, v);
        check({tag, "_valid"}, v, 1);
        check({tag, "_data"}, q, exp_q);
        check({tag, "_err"}, e, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_valid = 0; a_wen = 0; a_size = 0; a_uns = 0; a_add = 0; a_din = 0;
        b_valid = 0; b_wen = 0; b_size = 0; b_uns = 0; b_add = 0; b_din = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_a_rsp", a_rsp_valid, 0);
        check("rst_b_dout", b_dout, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_a_ready", a_ready, 1);
        check("post_rst_b_ready", b_ready, 1);
        check("post_rst_a_err", a_rsp_err, 0);

        // RD_LAT = 1 instance, back-to-back requests
        st1("st_w8", 2'b10, 32'h8, 32'hDEADBEEF, 0);
        ld1("ld_w8", 2'b10, 0, 32'h8, 32'hDEADBEEF, 0);
        st1("st_w10", 2'b10, 32'h10, 32'h80FF7F01, 0);
        ld1("ld_sb13", 2'b00, 0, 32'h13, 32'hFFFFFF80, 0);
        ld1("ld_ub12", 2'b00, 1, 32'h12, 32'h000000FF, 0);
        ld1("ld_sh10", 2'b01, 0, 32'h10, 32'h00007F01, 0);
        ld1("ld_sh12", 2'b01, 0, 32'h12, 32'hFFFF80FF, 0);
        ld1("ld_uh12", 2'b01, 1, 32'h12, 32'h000080FF, 0);
        ld1("ld_uw10", 2'b10, 1, 32'h10, 32'h80FF7F01, 0);
        st1("st_w20", 2'b10, 32'h20, 32'h11223344, 0);
        st1("st_b21", 2'b00, 32'h21, 32'hFFFFFFAA, 0);
        ld1("ld_merge_b", 2'b10, 0, 32'h20, 32'h1122AA44, 0);
        st1("st_h22", 2'b01, 32'h22, 32'h1234BEEF, 0);
        ld1("ld_merge_h", 2'b10, 0, 32'h20, 32'hBEEFAA44, 0);
        st1("st_wrap", 2'b00, 32'h400, 32'h0000005A, 0);
        ld1("ld_wrap", 2'b00, 1, 32'h0, 32'h0000005A, 0);
        st1("st_illegal", 2'b11, 32'h8, 32'h0, 1);
        ld1("ld_after_illegal", 2'b10, 0, 32'h8, 32'hDEADBEEF, 0);
        ld1("ld_illegal", 2'b11, 0, 32'h8, 32'h0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
        st1("st_mis_w22", 2'b10, 32'h22, 32'hCAFEF00D, 1);
        ld1("ld_mis_chk20", 2'b10, 0, 32'h20, 32'hBEEFAA44, 0);
        ld1("ld_mis_h23", 2'b01, 1, 32'h23, 32'h0, 1);
`else
        st1("st_mis_w22", 2'b10, 32'h22, 32'hCAFEF00D, 0);
        ld1("ld_mis_chk20", 2'b10, 0, 32'h20, 32'hCAFEF00D, 0);
        ld1("ld_mis_h23", 2'b01, 1, 32'h23, 32'h0000CAFE, 0);
`endif

        // RD_LAT = 3 instance: latency, backpressure, accept in response cycle
        b_wen = 1; b_size = 2'b10; b_uns = 0; b_add = 32'h40; b_din = 32'h01020304; b_valid = 1;
        @(posedge clk); #1;
        b_valid = 0;
        check("l3_st_valid", b_rsp_valid, 1);
        check("l3_st_data", b_dout, 0);
        b_wen = 0; b_size = 2'b10; b_add = 32'h40; b_valid = 1;
        check("l3_ready_T", b_ready, 1);
        @(posedge clk); #1;
        b_size = 2'b00; b_uns = 1; b_add = 32'h41;
        check("l3_ready_T1", b_ready, 0);
        check("l3_rsp_T1", b_rsp_valid, 0);
        @(posedge clk); #1;
        check("l3_ready_T2", b_ready, 0);
        check("l3_rsp_T2", b_rsp_valid, 0);
        @(posedge clk); #1;
        check("l3_rsp_T3", b_rsp_valid, 1);
        check("l3_data_T3", b_dout, 32'h01020304);
        check("l3_err_T3", b_rsp_err, 0);
        check("l3_ready_T3", b_ready, 1);
        @(posedge clk); #1;
        b_valid = 0;
        check("l3_ready_T4", b_ready, 0);
        check("l3_rsp_T4", b_rsp_valid, 0);
        @(posedge clk); #1;
        check("l3_ready_T5", b_ready, 0);
        @(posedge clk); #1;
        check("l3_rsp2_valid", b_rsp_valid, 1);
        check("l3_rsp2_data", b_dout, 32'h00000003);

        // reset during an outstanding load
        b_size = 2'b10; b_uns = 0; b_add = 32'h40; b_valid = 1;
        @(posedge clk); #1;
        b_valid = 0;
        rst = 1;
        check("l3_rst_ready", b_ready, 0);
        @(posedge clk); #1;
        check("l3_rst_rsp_a", b_rsp_valid, 0);
        check("l3_rst_data", b_dout, 0);
        check("l3_rst_err", b_rsp_err, 0);
        @(posedge clk); #1;
        check("l3_rst_rsp_b", b_rsp_valid, 0);
        rst = 0;
        @(posedge clk); #1;
        check("l3_post_rst_rsp", b_rsp_valid, 0);
        check("l3_post_rst_ready", b_ready, 1);
        @(posedge clk); #1;
        check("l3_post_rst_rsp2", b_rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
